simple_fifo_adapter: RTL and testbench
======================================

// Module: simple_fifo_adapter
// PURPOSE
//  Width-upsizing synchronous FIFO: packs RATIO = DATA_OUT_WIDTH/DATA_IN_WIDTH narrow
//  input words into one wide word and stores it in a 2^ADDR_WIDTH-deep wide FIFO.
//  Sits between a narrow producer (e.g. 16-bit stream) and a wide consumer (e.g. 128-bit bus).
// PARAMETERS
//  DATA_IN_WIDTH   16   input word width
//  DATA_OUT_WIDTH  128  output word width; integer multiple of DATA_IN_WIDTH, RATIO>=2
//  ADDR_WIDTH      4    log2 of wide-FIFO depth (DEPTH = 2^ADDR_WIDTH)
//  FULL_SLACK      1    wr_full asserts this many wide entries before true full; range 0..DEPTH-1
// PORTS
//  clk         in   1                 single clock, rising edge
//  rst         in   1                 synchronous, active-low reset
//  wr_ena      in   1                 write strobe for wr_dat
//  wr_dat      in   DATA_IN_WIDTH     narrow input word
//  wr_full     out  1                 write back-pressure
//  rd_ena      in   1                 read strobe
//  rd_dat      out  DATA_OUT_WIDTH    wide output word (registered)
//  rd_empty    out  1                 no wide word stored
//  rd_dat_cnt  out  ADDR_WIDTH+1      number of wide words stored, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): wr/rd pointers, count, pack index cleared; rd_dat=0,
//    rd_dat_cnt=0, rd_empty=1, wr_full=0 (or 1 if DEPTH-FULL_SLACK==0). Reset wins over all.
//  - Write accept: wr_ena && !wr_full. Accepted word goes to lane idx of assembly register
//    (lane 0 = bits[DATA_IN_WIDTH-1:0], first word in LSBs); idx increments.
//  - On the accept of the RATIO-th word (idx==RATIO-1) the completed wide word (including
//    this word) is written to RAM[wr_ptr] on that same edge; wr_ptr++, idx<=0.
//  - wr_ena while wr_full: word dropped, idx unchanged, no error flag.
//  - Partial assembly is never visible to the reader and is held indefinitely.
//  - Read accept: rd_ena && !rd_empty. rd_dat <= RAM[rd_ptr] on that edge, rd_ptr++;
//    data valid immediately after the edge (1-cycle latency). rd_ena while empty ignored,
//    rd_dat holds last value.
//  - count: +1 on completion only, -1 on read only, unchanged when both same edge.
//  - rd_dat_cnt = count (registered); rd_empty = (count==0);
//    wr_full = (count >= DEPTH-FULL_SLACK). Both derived from registered count.
//  - With completion allowed only while !wr_full, count never exceeds DEPTH (no overflow).
//  - Pointers ADDR_WIDTH bits, natural wrap DEPTH-1 -> 0.
//  - Read of the last entry and completion in the same edge when count==1: valid, count stays 1.
// STRUCTURE
//  - Shared package: RATIO, DEPTH, IDX_WIDTH=$clog2(RATIO) localparams.
//  - One sub-module: simple_fifo_adapter_ram (DEPTH x DATA_OUT_WIDTH simple dual-port,
//    sync write, sync registered read). Packer, pointers, count/flags in top.
// TESTING
//  - Reset: hold rst=0 2 cycles -> rd_empty=1, rd_dat_cnt=0, wr_full=0, rd_dat=0.
//  - Push 32 words 0..31, idle 10, pop 4 -> cnt 4 then 0; pop1 rd_dat=
//    0x0007_0006_0005_0004_0003_0002_0001_0000, pop4 lanes 0x18..0x1F.
//  - Push 128 words 0..127 (FULL_SLACK=1): wr_full asserts at cnt 15 after word 119;
//    words 120..127 dropped; 16 pops -> 15 words k={8k+7..8k}, 16th ignored, rd_dat holds.
//  - Push 16 random bytes, pop 2 -> exactly the two packed words in order, rd_empty=1.
//  - Streaming: wr_ena=1 (data 9) 32 cycles, then rd_ena=1 with writes 32 cycles ->
//    every output 0x0009 in all lanes; cnt never >15, constant over balanced completion/read.
//  - Reset mid-operation with cnt=3 and idx=5 -> all state cleared, next 8 pushes form word 0.

Source files
------------

// File: rtl/simple_fifo_adapter_pkg.sv
// simple_fifo_adapter_pkg: shared defaults and geometry helpers for the width-upsizing FIFO
package simple_fifo_adapter_pkg;
  localparam int DEF_DATA_IN_WIDTH = 16;
  localparam int DEF_DATA_OUT_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_FULL_SLACK = 1;
  localparam int RATIO = DEF_DATA_OUT_WIDTH / DEF_DATA_IN_WIDTH;
  localparam int DEPTH = 1 << DEF_ADDR_WIDTH;
  localparam int IDX_WIDTH = $clog2(RATIO);
  function automatic int lanes_of(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction
  function automatic int idx_width_of(input int lanes);
    return lanes > 1 ? $clog2(lanes) : 1;
  endfunction
endpackage

// File: rtl/simple_fifo_adapter_ram.sv
// simple_fifo_adapter_ram: simple dual-port storage with synchronous write and registered read
module simple_fifo_adapter_ram
  import simple_fifo_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  // storage array is never reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  // output register clears on reset and otherwise holds until the next accepted read
  always_ff @(posedge clk) begin
    if (!rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/simple_fifo_adapter.sv
// simple_fifo_adapter: packs narrow input words into wide words queued in a wide FIFO
module simple_fifo_adapter
  import simple_fifo_adapter_pkg::*;
#(
  parameter int DATA_IN_WIDTH = DEF_DATA_IN_WIDTH,
  parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FULL_SLACK = DEF_FULL_SLACK
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_ena,
  input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
  output logic                      wr_full,
  input  logic                      rd_ena,
  output logic [DATA_OUT_WIDTH-1:0] rd_dat,
  output logic                      rd_empty,
  output logic [ADDR_WIDTH:0]       rd_dat_cnt
);
  localparam int LANES = lanes_of(DATA_IN_WIDTH, DATA_OUT_WIDTH);
  localparam int ENTRIES = 1 << ADDR_WIDTH;
  localparam int IW = idx_width_of(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  localparam logic [IW-1:0] IDX_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
  logic [DATA_OUT_WIDTH-1:0] asm_q;
  logic [DATA_OUT_WIDTH-1:0] wide;
  logic [IW-1:0] idx;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic wr_acc;
  logic done;
  logic rd_acc;
  assign wr_full = int'(count) >= ENTRIES - FULL_SLACK;
  assign rd_empty = count == '0;
  assign rd_dat_cnt = count;
  assign wr_acc = wr_ena && !wr_full;
  assign done = wr_acc && idx == LAST;
  assign rd_acc = rd_ena && !rd_empty;
  // assembly register with the incoming word merged into its lane; on the last lane this is the finished word
  always_comb begin
    wide = asm_q;
    wide[int'(idx) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = wr_dat;
  end
  // packer: capture accepted words lane by lane, restarting at lane 0 after a completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      asm_q <= '0;
      idx <= '0;
    end else if (wr_acc) begin
      asm_q <= wide;
      idx <= done ? '0 : idx + IDX_ONE;
    end
  end
  // queue bookkeeping: pointers advance on completion/read, count tracks the difference
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= done ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr <= rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
      count <= done && !rd_acc ? count + CNT_ONE : rd_acc && !done ? count - CNT_ONE : count;
    end
  end
  simple_fifo_adapter_ram #(
    .DATA_WIDTH(DATA_OUT_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk(clk),
    .rst(rst),
    .wr_en(done),
    .wr_addr(wr_ptr),
    .wr_data(wide),
    .rd_en(rd_acc),
    .rd_addr(rd_ptr),
    .rd_data(rd_dat)
  );
endmodule

// File: tb/tb_simple_fifo_adapter.sv
// tb_simple_fifo_adapter: directed self-checking bench for the width-upsizing FIFO
module tb_simple_fifo_adapter;
  logic clk;
  logic rst;
  logic wr_ena;
  logic [15:0] wr_dat;
  logic wr_full;
  logic rd_ena;
  logic [127:0] rd_dat;
  logic rd_empty;
  logic [4:0] rd_dat_cnt;
  int errors = 0;
  int checks = 0;
  localparam logic [127:0] NINE = {8{16'h0009}};

  simple_fifo_adapter dut (
    .clk(clk),
    .rst(rst),
    .wr_ena(wr_ena),
    .wr_dat(wr_dat),
    .wr_full(wr_full),
    .rd_ena(rd_ena),
    .rd_dat(rd_dat),
    .rd_empty(rd_empty),
    .rd_dat_cnt(rd_dat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] pk(input int b);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) r[j*16 +: 16] = 16'(b + j);
    return r;
  endfunction

  task automatic push(input logic [15:0] w);
    wr_ena = 1'b1;
    wr_dat = w;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
  endtask

  task automatic pop();
    rd_ena = 1'b1;
    @(posedge clk);
    #1;
    rd_ena = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", rd_empty); end
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", rd_dat_cnt); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", wr_full); end
    checks++; if (rd_dat !== 128'h0) begin errors++; $display("FAIL reset_rd_dat got=%h exp=0", rd_dat); end
    rst = 1'b1;
  endtask

  task automatic test_pack();
    for (int i = 0; i < 32; i++) push(16'(i));
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rd_dat_cnt !== 5'd4) begin errors++; $display("FAIL pack_cnt got=%0d exp=4", rd_dat_cnt); end
    pop();
    checks++; if (rd_dat !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin errors++; $display("FAIL pack_pop1 got=%h exp=00070006000500040003000200010000", rd_dat); end
    for (int k = 1; k < 4; k++) begin
      pop();
      checks++; if (rd_dat !== pk(8 * k)) begin errors++; $display("FAIL pack_pop%0d got=%h exp=%h", k + 1, rd_dat, pk(8 * k)); end
    end
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("FAIL pack_cnt_end got=%0d exp=0", rd_dat_cnt); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL pack_empty got=%b exp=1", rd_empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 128; i++) begin
      push(16'(i));
      if (i == 111) begin
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL full_early got=%b exp=0", wr_full); end
        checks++; if (rd_dat_cnt !== 5'd14) begin errors++; $display("FAIL full_cnt14 got=%0d exp=14", rd_dat_cnt); end
      end
      if (i == 119) begin
        checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_assert got=%b exp=1", wr_full); end
        checks++; if (rd_dat_cnt !== 5'd15) begin errors++; $display("FAIL full_cnt15 got=%0d exp=15", rd_dat_cnt); end
      end
    end
    checks++; if (rd_dat_cnt !== 5'd15) begin errors++; $display("FAIL full_cnt_after_drop got=%0d exp=15", rd_dat_cnt); end
    for (int k = 0; k < 15; k++) begin
      pop();
      checks++; if (rd_dat !== pk(8 * k)) begin errors++; $display("FAIL full_pop%0d got=%h exp=%h", k, rd_dat, pk(8 * k)); end
    end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", rd_empty); end
    pop();
    checks++; if (rd_dat !== pk(112)) begin errors++; $display("FAIL full_hold got=%h exp=%h", rd_dat, pk(112)); end
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("FAIL full_cnt_ignored got=%0d exp=0", rd_dat_cnt); end
    for (int i = 0; i < 8; i++) push(16'(200 + i));
    pop();
    checks++; if (rd_dat !== pk(200)) begin errors++; $display("FAIL full_realign got=%h exp=%h", rd_dat, pk(200)); end
  endtask

  task automatic test_random();
    logic [15:0] b [16];
    logic [127:0] e;
    for (int i = 0; i < 16; i++) begin
      b[i] = 16'($urandom_range(0, 255));
      push(b[i]);
    end
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 8; j++) e[j*16 +: 16] = b[w*8 + j];
      pop();
      checks++; if (rd_dat !== e) begin errors++; $display("FAIL rand_word%0d got=%h exp=%h", w, rd_dat, e); end
    end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL rand_empty got=%b exp=1", rd_empty); end
  endtask

  task automatic test_stream();
    logic pre;
    wr_ena = 1'b1;
    wr_dat = 16'h0009;
    repeat (32) @(posedge clk);
    #1;
    checks++; if (rd_dat_cnt !== 5'd4) begin errors++; $display("FAIL stream_fill_cnt got=%0d exp=4", rd_dat_cnt); end
    rd_ena = 1'b1;
    for (int c = 0; c < 32; c++) begin
      pre = rd_empty;
      @(posedge clk);
      #1;
      if (!pre) begin
        checks++; if (rd_dat !== NINE) begin errors++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, rd_dat, NINE); end
      end
      checks++; if (!(rd_dat_cnt <= 5'd15)) begin errors++; $display("FAIL stream_cnt cyc=%0d got=%0d exp<=15", c, rd_dat_cnt); end
    end
    wr_ena = 1'b0;
    rd_ena = 1'b0;
    for (int i = 0; i < 20 && !rd_empty; i++) pop();
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL stream_drain got=%b exp=1", rd_empty); end
  endtask

  task automatic test_same_edge();
    for (int i = 0; i < 8; i++) push(16'(256 + i));
    for (int i = 0; i < 7; i++) push(16'(272 + i));
    checks++; if (rd_dat_cnt !== 5'd1) begin errors++; $display("FAIL same_pre_cnt got=%0d exp=1", rd_dat_cnt); end
    rd_ena = 1'b1;
    push(16'(279));
    rd_ena = 1'b0;
    checks++; if (rd_dat_cnt !== 5'd1) begin errors++; $display("FAIL same_cnt got=%0d exp=1", rd_dat_cnt); end
    checks++; if (rd_dat !== pk(256)) begin errors++; $display("FAIL same_rd got=%h exp=%h", rd_dat, pk(256)); end
    pop();
    checks++; if (rd_dat !== pk(272)) begin errors++; $display("FAIL same_next got=%h exp=%h", rd_dat, pk(272)); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL same_empty got=%b exp=1", rd_empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 29; i++) push(16'(1024 + i));
    checks++; if (rd_dat_cnt !== 5'd3) begin errors++; $display("FAIL mid_pre_cnt got=%0d exp=3", rd_dat_cnt); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", rd_dat_cnt); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", rd_empty); end
    checks++; if (rd_dat !== 128'h0) begin errors++; $display("FAIL mid_rd_dat got=%h exp=0", rd_dat); end
    for (int i = 0; i < 8; i++) push(16'(768 + i));
    checks++; if (rd_dat_cnt !== 5'd1) begin errors++; $display("FAIL mid_post_cnt got=%0d exp=1", rd_dat_cnt); end
    pop();
    checks++; if (rd_dat !== pk(768)) begin errors++; $display("FAIL mid_word got=%h exp=%h", rd_dat, pk(768)); end
  endtask

  initial begin
    rst = 1'b0;
    wr_ena = 1'b0;
    wr_dat = '0;
    rd_ena = 1'b0;
    test_reset();
    test_pack();
    test_full();
    test_random();
    test_stream();
    test_same_edge();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
